div_issue_sequencer: RTL and testbench

//  Sequential front end for the 7/4 combinational long divider (CAS-array divider).

---
 rtl/div_pkg.sv | 28 ++
 rtl/div_issue_sequencer_if.sv | 24 ++
 rtl/div_op_fifo.sv | 57 +++++
 rtl/div_issue_sequencer.sv | 109 ++++++++++
 tb/tb_div_issue_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, error encodings, FSM states and operand screening
package div_pkg;

    localparam int DW = 7;
    localparam int MW = 4;
    localparam int QW = 4;
    localparam int RW = 4;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        HOLD
    } state_t;

    // A quotient fits in QW bits only when the top dividend bits are below the divisor.
    function automatic logic [1:0] screen(input logic [DW-1:0] d, input logic [MW-1:0] m);
        if (m == '0)
            return ERR_DIV0;
        if ({1'b0, d[DW-1:DW-3]} >= m)
            return ERR_OVF;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/div_issue_sequencer_if.sv
// rtl/div_issue_sequencer_if.sv - operand input and result output handshakes
interface div_issue_sequencer_if;

    logic                    in_valid;
    logic                    in_ready;
    logic [div_pkg::DW-1:0]  in_D;
    logic [div_pkg::MW-1:0]  in_M;
    logic                    out_valid;
    logic                    out_ready;
    logic [div_pkg::QW-1:0]  out_Q;
    logic [div_pkg::RW-1:0]  out_R;
    logic [1:0]              out_err;

    modport master (
        output in_valid, in_D, in_M, out_ready,
        input  in_ready, out_valid, out_Q, out_R, out_err
    );

    modport slave (
        input  in_valid, in_D, in_M, out_ready,
        output in_ready, out_valid, out_Q, out_R, out_err
    );

endinterface

// File: rtl/div_op_fifo.sv
// rtl/div_op_fifo.sv - synchronous FIFO of {D, M} operand pairs
module div_op_fifo
    import div_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wr_D,
    input  logic [MW-1:0] wr_M,
    output logic [DW-1:0] rd_D,
    output logic [MW-1:0] rd_M,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [DW+MW-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign {rd_D, rd_M} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= {wr_D, wr_M};
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/div_issue_sequencer.sv
// rtl/div_issue_sequencer.sv - queues operand pairs, screens them and sequences the combinational divider
module div_issue_sequencer
    import div_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    div_issue_sequencer_if.slave io,
    output logic [DW-1:0]        div_D,
    output logic [MW-1:0]        div_M,
    input  logic [QW-1:0]        div_Q,
    input  logic [RW-1:0]        div_R,
    output logic                 busy
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            out_valid_q;
    logic [QW-1:0]   out_Q_q;
    logic [RW-1:0]   out_R_q;
    logic [1:0]      out_err_q;
    logic [DW-1:0]   head_D;
    logic [MW-1:0]   head_M;
    logic [1:0]      head_err;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [AW:0]     fifo_count;

    assign io.in_ready  = !full;
    assign io.out_valid = out_valid_q;
    assign io.out_Q     = out_Q_q;
    assign io.out_R     = out_R_q;
    assign io.out_err   = out_err_q;

    assign push     = io.in_valid && !full;
    assign pop      = !empty && (state == IDLE || (state == HOLD && io.out_ready));
    assign head_err = screen(head_D, head_M);
    assign busy     = (state != IDLE) || (fifo_count != '0);

    div_op_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wr_D  (io.in_D),
        .wr_M  (io.in_M),
        .rd_D  (head_D),
        .rd_M  (head_M),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            div_D       <= '0;
            div_M       <= '0;
            out_valid_q <= 1'b0;
            out_Q_q     <= '0;
            out_R_q     <= '0;
            out_err_q   <= ERR_NONE;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    // HOLD pops only on the accepting edge, so a queued pair follows back-to-back.
                    if (pop) begin
                        div_D <= head_D;
                        div_M <= head_M;
                        if (head_err != ERR_NONE) begin
                            out_Q_q     <= '1;
                            out_R_q     <= '0;
                            out_err_q   <= head_err;
                            out_valid_q <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            out_valid_q <= 1'b0;
                            cnt         <= CW'(SETTLE_CYCLES);
                            state       <= EVAL;
                        end
                    end else if (state == HOLD && io.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                EVAL: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        out_Q_q     <= div_Q;
                        out_R_q     <= div_R;
                        out_err_q   <= ERR_NONE;
                        out_valid_q <= 1'b1;
                        state       <= HOLD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_sequencer.sv
// tb/tb_div_issue_sequencer.sv - scoreboard bench for the divider issue sequencer
module tb_div_issue_sequencer;
    import div_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] div_D;
    logic [3:0] div_M;
    logic [3:0] div_Q;
    logic [3:0] div_R;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic [9:0] sb[$];

    always #5 clk = ~clk;

    div_issue_sequencer_if io();

    div_issue_sequencer dut (
        .clk   (clk),
        .rst   (rst),
        .io    (io),
        .div_D (div_D),
        .div_M (div_M),
        .div_Q (div_Q),
        .div_R (div_R),
        .busy  (busy)
    );

    always_comb begin
        div_Q = 4'hF;
        div_R = 4'h0;
        if (div_M != 4'd0) begin
            div_Q = 4'(div_D / {3'b000, div_M});
            div_R = 4'(div_D % {3'b000, div_M});
        end
    end

    function automatic logic [9:0] model(input int d, input int m);
        if (m == 0)
            return {2'b01, 4'hF, 4'h0};
        if (d >= 16 * m)
            return {2'b10, 4'hF, 4'h0};
        return {2'b00, 4'(d / m), 4'(d % m)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input int d, input int m, output bit acc);
        io.in_valid = 1'b1;
        io.in_D     = 7'(d);
        io.in_M     = 4'(m);
        acc         = io.in_ready;
        if (acc)
            sb.push_back(model(d, m));
        tick();
        io.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        io.in_valid = 1'b0; io.in_D = '0; io.in_M = '0; io.out_ready = 1'b0;
        repeat (2) tick();
        checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", io.in_ready); end
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", io.out_valid); end
        checks++; if ({io.out_err, io.out_Q, io.out_R} !== 10'h0) begin errors++; $display("FAIL reset_result: got %h expected 000", {io.out_err, io.out_Q, io.out_R}); end
        checks++; if ({div_D, div_M} !== 11'h0) begin errors++; $display("FAIL reset_div_ops: got %h expected 000", {div_D, div_M}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        int ds[3]   = '{100, 127, 111};
        int ms[3]   = '{7, 7, 7};
        int lats[3] = '{2, 1, 2};
        bit acc;
        int lat;
        logic [9:0] exp;
        io.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_pair(ds[i], ms[i], acc);
            lat = 0;
            while (!io.out_valid && lat < 10) begin tick(); lat++; end
            checks++; if (lat != lats[i]) begin errors++; $display("FAIL latency_%0d: got %0d expected %0d cycles", i, lat, lats[i]); end
            exp = sb.pop_front();
            checks++; if ({io.out_err, io.out_Q, io.out_R} !== exp) begin errors++; $display("FAIL result_%0d: got %h expected %h", i, {io.out_err, io.out_Q, io.out_R}, exp); end
            tick();
            checks++; if (io.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drained_%0d: got valid=%b busy=%b expected 0 0", i, io.out_valid, busy); end
        end
    endtask

    task automatic test_div0_then_good();
        bit acc;
        int n = 0;
        logic [9:0] exp;
        io.out_ready = 1'b1;
        push_pair(50, 0, acc);
        push_pair(9, 3, acc);
        for (int c = 0; c < 10 && n < 2; c++) begin
            if (io.out_valid) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
                checks++; if ({io.out_err, io.out_Q, io.out_R} !== exp) begin errors++; $display("FAIL div0_seq_%0d: got %h expected %h", n, {io.out_err, io.out_Q, io.out_R}, exp); end
                n++;
            end
            tick();
        end
        checks++; if (n != 2) begin errors++; $display("FAIL div0_count: got %0d expected 2 results", n); end
    endtask

    task automatic test_backpressure();
        int ds[6] = '{100, 111, 9, 50, 77, 30};
        int ms[6] = '{7, 7, 3, 5, 6, 4};
        bit acc;
        int n_acc = 0;
        int n = 0;
        int first = -1;
        logic [9:0] exp;
        io.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_pair(ds[i], ms[i], acc);
            if (acc) n_acc++;
        end
        checks++; if (n_acc != 5) begin errors++; $display("FAIL bp_accepted: got %0d expected 5", n_acc); end
        repeat (3) tick();
        checks++; if (io.in_ready !== 1'b0 || io.out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall: got in_ready=%b out_valid=%b expected 0 1", io.in_ready, io.out_valid); end
        io.out_ready = 1'b1;
        for (int c = 0; c < 30 && n < 5; c++) begin
            if (io.out_valid) begin
                if (first < 0) first = c;
                exp = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
                checks++; if ({io.out_err, io.out_Q, io.out_R} !== exp) begin errors++; $display("FAIL bp_result_%0d: got %h expected %h", n, {io.out_err, io.out_Q, io.out_R}, exp); end
                checks++; if (c - first != 2 * n) begin errors++; $display("FAIL bp_spacing_%0d: got cycle %0d expected %0d", n, c - first, 2 * n); end
                n++;
            end
            tick();
        end
        checks++; if (n != 5 || busy !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0d results busy=%b expected 5 0", n, busy); end
    endtask

    task automatic test_mid_reset();
        bit acc;
        int seen = 0;
        io.out_ready = 1'b0;
        push_pair(10, 3, acc);
        push_pair(20, 3, acc);
        push_pair(30, 3, acc);
        push_pair(40, 3, acc);
        io.out_ready = 1'b1;
        push_pair(60, 5, acc);
        checks++; if (io.out_valid !== 1'b0 || busy !== 1'b1 || dut.u_fifo.count !== 3'd3) begin errors++; $display("FAIL pre_reset: got valid=%b busy=%b count=%0d expected 0 1 3", io.out_valid, busy, dut.u_fifo.count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (io.out_valid !== 1'b0 || {io.out_err, io.out_Q, io.out_R} !== 10'h0) begin errors++; $display("FAIL async_reset_out: got valid=%b result=%h expected 0 000", io.out_valid, {io.out_err, io.out_Q, io.out_R}); end
        checks++; if ({div_D, div_M} !== 11'h0 || busy !== 1'b0 || io.in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_misc: got div=%h busy=%b in_ready=%b expected 000 0 1", {div_D, div_M}, busy, io.in_ready); end
        sb.delete();
        tick();
        rst = 1'b0;
        repeat (10) begin
            tick();
            if (io.out_valid) seen++;
        end
        checks++; if (seen != 0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_quiet: got %0d results busy=%b expected 0 0", seen, busy); end
    endtask

    task automatic test_simul_push_pop();
        bit acc;
        int n = 0;
        logic [9:0] exp;
        io.out_ready = 1'b0;
        push_pair(10, 3, acc);
        push_pair(20, 3, acc);
        push_pair(30, 3, acc);
        checks++; if (dut.u_fifo.count !== 3'd2 || io.out_valid !== 1'b1) begin errors++; $display("FAIL simul_pre: got count=%0d valid=%b expected 2 1", dut.u_fifo.count, io.out_valid); end
        exp = sb.pop_front();
        checks++; if ({io.out_err, io.out_Q, io.out_R} !== exp) begin errors++; $display("FAIL simul_first: got %h expected %h", {io.out_err, io.out_Q, io.out_R}, exp); end
        io.out_ready = 1'b1;
        push_pair(40, 3, acc);
        checks++; if (dut.u_fifo.count !== 3'd2) begin errors++; $display("FAIL simul_count: got %0d expected 2", dut.u_fifo.count); end
        for (int c = 0; c < 20 && n < 3; c++) begin
            if (io.out_valid) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
                checks++; if ({io.out_err, io.out_Q, io.out_R} !== exp) begin errors++; $display("FAIL simul_order_%0d: got %h expected %h", n, {io.out_err, io.out_Q, io.out_R}, exp); end
                n++;
            end
            tick();
        end
        checks++; if (n != 3) begin errors++; $display("FAIL simul_results: got %0d expected 3", n); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_div0_then_good();
        test_backpressure();
        test_mid_reset();
        test_simul_push_pop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
